// File: rtl/serial_program_loader.sv
// UART (8N1) program-image loader: receives SYNC/LEN/DATA/SUM frames and drives the
// program memory write port, holding the CPU while a load is pending or has failed.
module serial_program_loader #(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          ADDR_W       = 4,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int          TIMEOUT_CLKS = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic              prog_we,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [7:0]        prog_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);

   localparam int CNT_W   = $clog2(CLKS_PER_BIT);
   localparam int HALF    = CLKS_PER_BIT / 2;
   localparam int LEN_W   = ADDR_W + 1;
   localparam int TO_W    = $clog2(TIMEOUT_CLKS + 1);
   localparam int MAX_LEN = 1 << ADDR_W;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
   typedef enum logic [1:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM} frameState_t;

   logic rxMeta, rxSync, rxPrev;

   rxState_t         rxState, rxStateNext;
   logic [CNT_W-1:0] bitCnt, bitCntNext;
   logic [2:0]       bitIdx, bitIdxNext;
   logic [7:0]       shiftReg, shiftNext;
   logic             byteValid, byteValidNext;
   logic             frameErr, frameErrNext;

   frameState_t       frameState, frameStateNext;
   logic [LEN_W-1:0]  lenReg, lenNext;
   logic [LEN_W-1:0]  idxReg, idxNext;
   logic [7:0]        sumReg, sumNext;
   logic [TO_W-1:0]   toCnt, toNext;
   logic              weNext, doneNext, errNext, holdNext;
   logic [ADDR_W-1:0] addrNext;
   logic [7:0]        dataNext;
   logic              abortFrame;

   // Input synchronizer; rxPrev gives falling-edge detection on the clean signal
   always_ff @(posedge clk) begin
      if (rst) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
         rxPrev <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxSync <= rxMeta;
         rxPrev <= rxSync;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rxState   <= RX_IDLE;
         bitCnt    <= '0;
         bitIdx    <= '0;
         byteValid <= 1'b0;
         frameErr  <= 1'b0;
      end else begin
         rxState   <= rxStateNext;
         bitCnt    <= bitCntNext;
         bitIdx    <= bitIdxNext;
         byteValid <= byteValidNext;
         frameErr  <= frameErrNext;
      end
   end

   always_ff @(posedge clk) begin
      shiftReg <= shiftNext;
   end

   always_comb begin
      rxStateNext   = rxState;
      bitCntNext    = bitCnt;
      bitIdxNext    = bitIdx;
      shiftNext     = shiftReg;
      byteValidNext = 1'b0;
      frameErrNext  = 1'b0;
      case (rxState)
         RX_IDLE: begin
            if (rxPrev && !rxSync) begin
               rxStateNext = RX_START;
               bitCntNext  = '0;
            end
         end
         RX_START: begin
            // Mid-start-bit check rejects glitches shorter than half a bit
            if (bitCnt == CNT_W'(HALF - 1)) begin
               bitCntNext = '0;
               bitIdxNext = '0;
               rxStateNext = rxSync ? RX_IDLE : RX_DATA;
            end else begin
               bitCntNext = bitCnt + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (bitCnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               bitCntNext = '0;
               shiftNext  = {rxSync, shiftReg[7:1]};
               if (bitIdx == 3'd7) rxStateNext = RX_STOP;
               else                bitIdxNext  = bitIdx + 3'd1;
            end else begin
               bitCntNext = bitCnt + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (bitCnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               byteValidNext = rxSync;
               frameErrNext  = !rxSync;
               rxStateNext   = RX_IDLE;
            end else begin
               bitCntNext = bitCnt + CNT_W'(1);
            end
         end
         default: rxStateNext = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frameState <= WAIT_SYNC;
         lenReg     <= '0;
         idxReg     <= '0;
         sumReg     <= '0;
         toCnt      <= '0;
         prog_we    <= 1'b0;
         prog_addr  <= '0;
         prog_data  <= '0;
         cpu_hold   <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         frameState <= frameStateNext;
         lenReg     <= lenNext;
         idxReg     <= idxNext;
         sumReg     <= sumNext;
         toCnt      <= toNext;
         prog_we    <= weNext;
         prog_addr  <= addrNext;
         prog_data  <= dataNext;
         cpu_hold   <= holdNext;
         load_done  <= doneNext;
         load_err   <= errNext;
      end
   end

   always_comb begin
      frameStateNext = frameState;
      lenNext        = lenReg;
      idxNext        = idxReg;
      sumNext        = sumReg;
      weNext         = 1'b0;
      doneNext       = 1'b0;
      errNext        = 1'b0;
      holdNext       = cpu_hold;
      addrNext       = prog_addr;
      dataNext       = prog_data;
      abortFrame     = 1'b0;
      toNext         = (frameState == WAIT_SYNC || byteValid) ? '0 : toCnt + TO_W'(1);

      case (frameState)
         WAIT_SYNC: begin
            if (byteValid && shiftReg == SYNC_BYTE) begin
               frameStateNext = GET_LEN;
               holdNext       = 1'b1;
               sumNext        = '0;
               idxNext        = '0;
            end
         end
         GET_LEN: begin
            if (byteValid) begin
               if (shiftReg == 8'd0 || 32'(shiftReg) > MAX_LEN) begin
                  abortFrame = 1'b1;
               end else begin
                  lenNext        = LEN_W'(shiftReg);
                  frameStateNext = GET_DATA;
               end
            end
         end
         GET_DATA: begin
            if (byteValid) begin
               weNext   = 1'b1;
               addrNext = idxReg[ADDR_W-1:0];
               dataNext = shiftReg;
               sumNext  = sumReg + shiftReg;
               idxNext  = idxReg + LEN_W'(1);
               if (idxReg == lenReg - LEN_W'(1)) frameStateNext = GET_SUM;
            end
         end
         GET_SUM: begin
            if (byteValid) begin
               if (shiftReg == sumReg) begin
                  doneNext       = 1'b1;
                  holdNext       = 1'b0;
                  frameStateNext = WAIT_SYNC;
               end else begin
                  abortFrame = 1'b1;
               end
            end
         end
         default: frameStateNext = WAIT_SYNC;
      endcase

      // Line errors and inter-byte stalls only matter once a frame has started
      if (frameState != WAIT_SYNC && !byteValid &&
          (frameErr || toCnt == TO_W'(TIMEOUT_CLKS - 1))) begin
         abortFrame = 1'b1;
      end

      if (abortFrame) begin
         errNext        = 1'b1;
         frameStateNext = WAIT_SYNC;
      end
   end

   assign busy = (frameState != WAIT_SYNC);

endmodule

// File: tb/tb_serial_program_loader.sv
// Self-checking bench for serial_program_loader: frame vectors plus hand-written
// sequences for glitch, framing error, timeout and mid-frame reset.
module tb_serial_program_loader;

   localparam int B    = 16;
   localparam int TOUT = 4096;

   logic       clk, rst, rx;
   logic       prog_we, cpu_hold, busy, load_done, load_err;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;

   serial_program_loader #(
      .CLKS_PER_BIT(B), .ADDR_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TOUT)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [19:0][7:0] bytes;
      int               n;
      int               wOff;
      int               nWr;
      logic             expDone;
      logic             expErr;
      logic             expHold;
   } vec_t;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   vec_t vecs[7];
   wr_t  expQ[$];
   wr_t  mon;
   int   checks = 0;
   int   errors = 0;
   int   doneCnt = 0;
   int   errCnt = 0;
   int   weCnt = 0;

   // Scoreboard side: every write strobe pops one expected (addr, data)
   always @(negedge clk) begin
      if (!rst) begin
         if (prog_we) begin
            weCnt++;
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr=%0h data=%0h required=none", prog_addr, prog_data);
            end else begin
               mon = expQ.pop_front();
               if ({prog_addr, prog_data} !== mon) begin
                  errors++;
                  $display("FAIL write actual=(%0h,%0h) required=(%0h,%0h)",
                           prog_addr, prog_data, mon.a, mon.d);
               end
            end
            checks++;
            if (!busy) begin
               errors++;
               $display("FAIL we_outside_frame actual busy=0 required busy=1");
            end
         end
         if (load_done) doneCnt++;
         if (load_err) errCnt++;
         if (load_done || load_err) begin
            checks++;
            if (load_done && load_err) begin
               errors++;
               $display("FAIL done_and_err actual=both required=one");
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      rx = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (B) @(negedge clk);
      end
      rx = stopBit;
      repeat (B) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   function automatic vec_t mk(input logic [159:0] raw, input int n, input int wOff,
                               input int nWr, input logic dn, input logic er, input logic hd);
      vec_t r;
      r = '0;
      for (int i = 0; i < n; i++) r.bytes[i] = raw[8*(n-1-i) +: 8];
      r.n = n; r.wOff = wOff; r.nWr = nWr;
      r.expDone = dn; r.expErr = er; r.expHold = hd;
      return r;
   endfunction

   task automatic runVec(input int v);
      int d0, e0, w0;
      d0 = doneCnt; e0 = errCnt; w0 = weCnt;
      for (int k = 0; k < vecs[v].nWr; k++)
         expQ.push_back({4'(k), vecs[v].bytes[vecs[v].wOff + k]});
      for (int i = 0; i < vecs[v].n; i++) sendByte(vecs[v].bytes[i], 1'b1);
      repeat (20) @(negedge clk);
      check($sformatf("v%0d_done", v), doneCnt - d0, 32'(vecs[v].expDone));
      check($sformatf("v%0d_err", v), errCnt - e0, 32'(vecs[v].expErr));
      check($sformatf("v%0d_writes", v), weCnt - w0, vecs[v].nWr);
      check($sformatf("v%0d_hold", v), cpu_hold, vecs[v].expHold);
      check($sformatf("v%0d_busy", v), busy, 0);
      check($sformatf("v%0d_pending", v), expQ.size(), 0);
      expQ.delete();
   endtask

   initial begin
      int d0, e0, w0;
      logic [7:0] s;

      vecs[0] = mk(160'hA5_03_11_22_33_66, 6, 2, 3, 1'b1, 1'b0, 1'b0);
      vecs[1] = mk(160'hA5_02_10_20_00, 5, 2, 2, 1'b0, 1'b1, 1'b1);
      vecs[2] = mk(160'hA5_02_10_20_30, 5, 2, 2, 1'b1, 1'b0, 1'b0);
      vecs[3] = mk(160'hA5_00, 2, 2, 0, 1'b0, 1'b1, 1'b1);
      vecs[4] = mk(160'hA5_11, 2, 2, 0, 1'b0, 1'b1, 1'b1);
      vecs[5] = mk(160'h00_FF_5A_A5_01_A5_A5, 7, 5, 1, 1'b1, 1'b0, 1'b0);
      vecs[6] = mk(160'hA5_10, 2, 2, 16, 1'b1, 1'b0, 1'b0);
      s = 8'h00;
      for (int i = 0; i < 16; i++) begin
         vecs[6].bytes[2 + i] = 8'(i + 1);
         s = s + 8'(i + 1);
      end
      vecs[6].bytes[18] = s;
      vecs[6].n = 19;

      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_outputs", {prog_we, prog_addr, prog_data, cpu_hold, busy, load_done, load_err}, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_hold", cpu_hold, 0);

      // Half-bit glitch inside a frame must not be taken as a data byte
      d0 = doneCnt; e0 = errCnt; w0 = weCnt;
      expQ.push_back({4'h0, 8'h5A});
      sendByte(8'hA5, 1'b1);
      check("sync_hold", cpu_hold, 1);
      check("sync_busy", busy, 1);
      sendByte(8'h01, 1'b1);
      rx = 1'b0;
      repeat (B / 2) @(negedge clk);
      rx = 1'b1;
      repeat (3 * B) @(negedge clk);
      check("glitch_writes", weCnt - w0, 0);
      check("glitch_busy", busy, 1);
      sendByte(8'h5A, 1'b1);
      sendByte(8'h5A, 1'b1);
      repeat (20) @(negedge clk);
      check("glitch_done", doneCnt - d0, 1);
      check("glitch_err", errCnt - e0, 0);
      check("glitch_hold", cpu_hold, 0);
      expQ.delete();

      // Framing error on the first data byte aborts the frame
      d0 = doneCnt; e0 = errCnt; w0 = weCnt;
      sendByte(8'hA5, 1'b1);
      sendByte(8'h02, 1'b1);
      sendByte(8'h10, 1'b0);
      repeat (20) @(negedge clk);
      check("frm_err", errCnt - e0, 1);
      check("frm_done", doneCnt - d0, 0);
      check("frm_writes", weCnt - w0, 0);
      check("frm_busy", busy, 0);
      check("frm_hold", cpu_hold, 1);

      // Stall after LEN: no error just short of the limit, error after it
      e0 = errCnt;
      sendByte(8'hA5, 1'b1);
      sendByte(8'h02, 1'b1);
      repeat (TOUT - 100) @(negedge clk);
      check("to_early_err", errCnt - e0, 0);
      check("to_early_busy", busy, 1);
      repeat (200) @(negedge clk);
      check("to_err", errCnt - e0, 1);
      check("to_busy", busy, 0);
      check("to_hold", cpu_hold, 1);

      for (int v = 0; v < 7; v++) runVec(v);

      // Reset in the middle of GET_DATA while a byte is arriving
      d0 = doneCnt; e0 = errCnt; w0 = weCnt;
      expQ.push_back({4'h0, 8'h11});
      expQ.push_back({4'h1, 8'h22});
      sendByte(8'hA5, 1'b1);
      sendByte(8'h04, 1'b1);
      sendByte(8'h11, 1'b1);
      sendByte(8'h22, 1'b1);
      check("mid_hold", cpu_hold, 1);
      rx = 1'b0;
      repeat (3 * B) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_outputs", {prog_we, prog_addr, prog_data, cpu_hold, busy, load_done, load_err}, 0);
      rx  = 1'b1;
      rst = 1'b0;
      repeat (12 * B) @(negedge clk);
      check("mid_writes", weCnt - w0, 2);
      check("mid_err", errCnt - e0, 0);
      check("mid_done", doneCnt - d0, 0);
      check("mid_busy", busy, 0);
      check("mid_hold_after", cpu_hold, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
